// File: rtl/cache_2way_pkg.sv
// Shared types and geometry for the two-way set-associative write-back cache.
package cache_types;

  localparam int S_OFFSET_W = 5;
  localparam int S_INDEX_W  = 3;
  localparam int S_TAG      = 32 - S_INDEX_W - S_OFFSET_W;
  localparam int S_LINE     = 8 * (2 ** S_OFFSET_W);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  typedef logic way_t;

endpackage

// File: rtl/cache_2way_array.sv
// Small register-file array: combinational read, masked synchronous write,
// optional synchronous clear used by the valid, dirty and lru bits.
module cache_array #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 8,
  parameter int MASK_W     = 1,
  parameter bit RESETTABLE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [MASK_W-1:0]        wmask,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int GRAN = WIDTH / MASK_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Each mask bit guards one GRAN-wide slice so a single word of a line can be updated.
  always_ff @(posedge clk) begin
    if (RESETTABLE && rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int m = 0; m < MASK_W; m++) begin
        if (wmask[m]) mem_q[addr][m*GRAN +: GRAN] <= wdata[m*GRAN +: GRAN];
      end
    end
  end

endmodule

// File: rtl/cache_2way.sv
// Two-way set-associative, write-back, write-allocate cache between the CPU
// and a 256-bit line memory, with one pseudo-LRU bit per set.
module cache_2way
  import cache_types::*;
#(
  parameter int S_OFFSET = S_OFFSET_W,
  parameter int S_INDEX  = S_INDEX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [8*(2**S_OFFSET)-1:0] pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_W = 8 * (2 ** S_OFFSET);
  localparam int WORDS  = 2 ** (S_OFFSET - 2);
  localparam int WSEL_W = S_OFFSET - 2;

  logic [TAG_W-1:0]   reqTag;
  logic [S_INDEX-1:0] reqIndex;
  logic [WSEL_W-1:0]  reqWord;
  logic               unusedAddrBits;

  assign reqTag         = mem_address[31 -: TAG_W];
  assign reqIndex       = mem_address[S_OFFSET +: S_INDEX];
  assign reqWord        = mem_address[2 +: WSEL_W];
  assign unusedAddrBits = ^mem_address[1:0];

  state_t state_q, state_d;
  way_t   victim_q, victim_d;

  logic [TAG_W-1:0]  tagRd  [2];
  logic [LINE_W-1:0] lineRd [2];
  logic [1:0]        validRd, dirtyRd, hitVec;
  logic [1:0]        tagWe, dataWe, validWe, dirtyWe;
  logic [WORDS-1:0]  dataMask;
  logic [LINE_W-1:0] dataWdata;
  logic              dirtyWdata, lruRd, lruWe, lruWdata, hit;
  way_t              hitWay, missVictim;
  logic [LINE_W-1:0] hitLine;
  logic [31:0]       oldWord, mergedWord;

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_array #(.WIDTH(TAG_W), .DEPTH(2**S_INDEX), .MASK_W(1), .RESETTABLE(1'b0)) uTag (
      .clk(clk), .rst(rst), .we(tagWe[w]), .wmask(1'b1), .addr(reqIndex),
      .wdata(reqTag), .rdata(tagRd[w]));
    cache_array #(.WIDTH(LINE_W), .DEPTH(2**S_INDEX), .MASK_W(WORDS), .RESETTABLE(1'b0)) uData (
      .clk(clk), .rst(rst), .we(dataWe[w]), .wmask(dataMask), .addr(reqIndex),
      .wdata(dataWdata), .rdata(lineRd[w]));
    cache_array #(.WIDTH(1), .DEPTH(2**S_INDEX), .MASK_W(1), .RESETTABLE(1'b1)) uValid (
      .clk(clk), .rst(rst), .we(validWe[w]), .wmask(1'b1), .addr(reqIndex),
      .wdata(1'b1), .rdata(validRd[w]));
    cache_array #(.WIDTH(1), .DEPTH(2**S_INDEX), .MASK_W(1), .RESETTABLE(1'b1)) uDirty (
      .clk(clk), .rst(rst), .we(dirtyWe[w]), .wmask(1'b1), .addr(reqIndex),
      .wdata(dirtyWdata), .rdata(dirtyRd[w]));
    assign hitVec[w] = validRd[w] && (tagRd[w] == reqTag);
  end

  cache_array #(.WIDTH(1), .DEPTH(2**S_INDEX), .MASK_W(1), .RESETTABLE(1'b1)) uLru (
    .clk(clk), .rst(rst), .we(lruWe), .wmask(1'b1), .addr(reqIndex),
    .wdata(lruWdata), .rdata(lruRd));

  assign hit        = |hitVec;
  assign hitWay     = hitVec[1];
  assign hitLine    = lineRd[hitWay];
  assign oldWord    = hitLine[reqWord*32 +: 32];
  assign mem_rdata  = oldWord;
  assign pmem_wdata = lineRd[victim_q];
  // Empty ways are filled before anything is evicted; lru only decides between two valid ways.
  assign missVictim = !validRd[0] ? 1'b0 : (!validRd[1] ? 1'b1 : lruRd);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      mergedWord[b*8 +: 8] = mem_byte_enable[b] ? mem_wdata[b*8 +: 8] : oldWord[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    tagWe        = '0;
    dataWe       = '0;
    validWe      = '0;
    dirtyWe      = '0;
    dirtyWdata   = 1'b0;
    dataMask     = '0;
    dataWdata    = pmem_rdata;
    lruWe        = 1'b0;
    lruWdata     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp = !rst;
            lruWe    = 1'b1;
            lruWdata = ~hitWay;
            if (mem_write) begin
              dataWe[hitWay]    = 1'b1;
              dataMask[reqWord] = 1'b1;
              dataWdata         = {WORDS{mergedWord}};
              dirtyWe[hitWay]   = 1'b1;
              dirtyWdata        = 1'b1;
            end
          end else begin
            victim_d = missVictim;
            state_d  = (validRd[missVictim] && dirtyRd[missVictim]) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tagRd[victim_q], reqIndex, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          dirtyWe[victim_q] = 1'b1;
          dirtyWdata        = 1'b0;
          state_d           = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {reqTag, reqIndex, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          dataWe[victim_q]  = 1'b1;
          dataMask          = '1;
          tagWe[victim_q]   = 1'b1;
          validWe[victim_q] = 1'b1;
          dirtyWe[victim_q] = 1'b1;
          dirtyWdata        = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_2way.sv
// Bench for cache_2way: directed scenarios then random traffic, checked against
// a flat-memory view plus a per-set tag/valid/dirty/lru model.
module tb_cache_2way;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_2way dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

  int total = 0;
  int bad   = 0;

  logic [255:0] pmemStore [logic [31:0]];
  logic [31:0]  flatMem   [logic [31:0]];
  bit           mValid [8][2];
  bit           mDirty [8][2];
  logic [23:0]  mTag   [8][2];
  bit           mLru   [8];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] pmemLine(input logic [31:0] la);
    logic [255:0] ln;
    if (pmemStore.exists(la)) return pmemStore[la];
    for (int i = 0; i < 8; i++) ln[i*32 +: 32] = initWord(la + 32'(i * 4));
    return ln;
  endfunction

  // The CPU-visible value of a word: its last CPU write, else what memory holds.
  function automatic logic [31:0] goldenWord(input logic [31:0] a);
    logic [31:0]  wa, la;
    logic [255:0] ln;
    wa = {a[31:2], 2'b00};
    la = {a[31:5], 5'b0};
    if (flatMem.exists(wa)) return flatMem[wa];
    ln = pmemLine(la);
    return ln[32*int'(a[4:2]) +: 32];
  endfunction

  function automatic logic [255:0] goldenLine(input logic [31:0] la);
    logic [255:0] ln;
    for (int i = 0; i < 8; i++) ln[i*32 +: 32] = goldenWord(la + 32'(i * 4));
    return ln;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Dirty lines die with a reset, so the CPU view falls back to memory contents.
  task automatic resetModel();
    for (int s = 0; s < 8; s++) begin
      mLru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mValid[s][w] = 1'b0;
        mDirty[s][w] = 1'b0;
      end
    end
    flatMem.delete();
  endtask

  task automatic pulseResp(input logic [255:0] data);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int           setIdx, way, cycles;
    logic [23:0]  tg;
    bit           expHit, expWb, sawWb, sawFill, done, firstResp;
    logic [31:0]  wbAddr, fillAddr, expRdata, newW;
    logic [255:0] wbLine;
    setIdx   = int'(addr[7:5]);
    tg       = addr[31:8];
    expHit   = 1'b0;
    way      = 0;
    expWb    = 1'b0;
    wbAddr   = '0;
    wbLine   = '0;
    fillAddr = {addr[31:5], 5'b0};
    for (int w = 0; w < 2; w++) begin
      if (mValid[setIdx][w] && mTag[setIdx][w] == tg) begin
        expHit = 1'b1;
        way    = w;
      end
    end
    if (!expHit) begin
      if (!mValid[setIdx][0]) way = 0;
      else if (!mValid[setIdx][1]) way = 1;
      else way = int'(mLru[setIdx]);
      expWb  = mValid[setIdx][way] && mDirty[setIdx][way];
      wbAddr = {mTag[setIdx][way], addr[7:5], 5'b0};
      if (expWb) wbLine = goldenLine(wbAddr);
      mDirty[setIdx][way] = 1'b0;
    end
    expRdata = goldenWord(addr);
    mValid[setIdx][way] = 1'b1;
    mTag[setIdx][way]   = tg;
    mLru[setIdx]        = (way == 0);
    if (wr) begin
      for (int b = 0; b < 4; b++) newW[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : expRdata[b*8 +: 8];
      flatMem[{addr[31:2], 2'b00}] = newW;
      mDirty[setIdx][way] = 1'b1;
    end

    @(posedge clk); #1;
    mem_address     = addr;
    mem_read        = !wr;
    mem_write       = wr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    cycles = 0; sawWb = 1'b0; sawFill = 1'b0; done = 1'b0; firstResp = 1'b0;
    while (!done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      checkOutput("pmem_excl", {255'b0, pmem_read & pmem_write}, 256'b0);
      if (mem_resp) begin
        done      = 1'b1;
        firstResp = (cycles == 1);
      end else if (pmem_write) begin
        checkOutput("wb_addr", pmem_address, wbAddr);
        checkOutput("wb_data", pmem_wdata, wbLine);
        sawWb = 1'b1;
        pmemStore[pmem_address] = pmem_wdata;
        pulseResp('0);
      end else if (pmem_read) begin
        checkOutput("fill_addr", pmem_address, fillAddr);
        sawFill = 1'b1;
        pulseResp(pmemLine(fillAddr));
        checkOutput("fill_then_resp", mem_resp, 1'b1);
        done = 1'b1;
      end
    end
    checkOutput("resp_timeout", done, 1'b1);
    if (!wr) checkOutput("rdata", mem_rdata, expRdata);
    checkOutput("hit_latency", firstResp, expHit);
    checkOutput("saw_wb", sawWb, expWb);
    checkOutput("saw_fill", sawFill, !expHit);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    checkOutput("resp_single", mem_resp, 1'b0);
  endtask

  initial begin
    logic [255:0] seed;
    int           cycles;
    rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    resetModel();
    seed = pmemLine(32'h0000_1060);
    seed[63:32] = 32'hDEAD_BEEF;
    pmemStore[32'h0000_1060] = seed;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_resp", mem_resp, 1'b0);
    checkOutput("reset_pmem_read", pmem_read, 1'b0);
    checkOutput("reset_pmem_write", pmem_write, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, hit, byte-merged write, then fill way1 and force a dirty then a clean eviction.
    applyStimulus(1'b0, 32'h0000_1064, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_1064, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0000_1064, 32'h1122_3344, 4'b0101);
    applyStimulus(1'b0, 32'h0000_1064, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_2064, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_3064, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_4064, 32'h0, 4'h0);

    @(posedge clk); #1;
    mem_address = 32'h0000_5064;
    mem_read    = 1'b1;
    cycles      = 0;
    @(negedge clk);
    while (!pmem_read && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("rst_fill_seen", pmem_read, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    checkOutput("rst_pmem_read", pmem_read, 1'b0);
    checkOutput("rst_pmem_write", pmem_write, 1'b0);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    checkOutput("stray_pmem_read", pmem_read, 1'b0);
    checkOutput("stray_mem_resp", mem_resp, 1'b0);
    resetModel();
    applyStimulus(1'b0, 32'h0000_4064, 32'h0, 4'h0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {21'b0, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 3'($urandom), 2'b00};
      applyStimulus(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_2way.md
Name: cache_2way

Overview:
- Two-way set-associative, write-back, write-allocate cache.
- Sits directly downstream of the multicycle RV32I CPU control/datapath. It consumes mem_read, mem_write, mem_byte_enable, the address and the write data, and returns mem_rdata with a mem_resp pulse.
- Misses are serviced through a 256-bit line interface to physical memory.
- Pseudo-LRU uses one bit per set.

Parameters:
- S_OFFSET, 5, log2 of line size in bytes (32-byte line, 8 words).
- S_INDEX, 3, log2 of the set count (8 sets).
- Derived, not overridable: S_TAG = 32 - S_INDEX - S_OFFSET (24), S_LINE = 8 * 2**S_OFFSET (256).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_address  in  32  CPU byte address; bits [1:0] ignored.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  4  byte lanes for a write.
- mem_wdata  in  32  CPU write data.
- mem_rdata  out  32  read data; valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned memory address; low S_OFFSET bits are 0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_wdata  out  256  victim line data.
- pmem_rdata  in  256  fill line data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Address split: tag = [31:8], index = [7:5], word = [4:2].
- Per set and way the block holds valid, dirty, tag and a 256-bit line. Per set it holds an lru bit; lru names the way to evict.
- Arrays have combinational read and write on the clock edge.
- Reset:
  - All valid, dirty and lru bits cleared; state = IDLE.
  - mem_resp, pmem_read and pmem_write = 0.
  - Tag and data contents are don't-care.
- States: IDLE, WRITEBACK, FILL.
- IDLE:
  - On a request, hit = valid[w] && tag[w] == tag, for either way w.
  - Read hit: mem_resp = 1 the same cycle. mem_rdata = word `word` of the hit line. lru[index] <= ~w.
  - Write hit: mem_resp = 1 the same cycle. Byte lanes with mem_byte_enable=1 are merged into word `word` on the edge. dirty <= 1; lru[index] <= ~w.
  - Miss, victim selection: first invalid way (way0 before way1), else lru[index].
  - Miss with victim valid and dirty: next state = WRITEBACK. Otherwise next state = FILL.
  - mem_write has priority if mem_write and mem_read are both asserted (illegal from the CPU).
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line.
  - On pmem_resp: dirty[victim] <= 0, next state = FILL.
- FILL:
  - pmem_read = 1, pmem_address = {tag, index, 5'b0}.
  - On pmem_resp: line <= pmem_rdata, tag <= tag, valid <= 1, dirty <= 0; next state = IDLE.
  - The request then hits in IDLE on the following cycle.
- Victim choice is latched on leaving IDLE and held through WRITEBACK and FILL.
- Latency:
  - Hit: 0 added cycles (response in the cycle the request is first seen).
  - Clean miss: fill duration + 1.
  - Dirty miss: writeback + fill + 1.
- mem_resp is never asserted outside IDLE and never for two consecutive cycles on one request. The CPU drops its request the cycle after mem_resp.
- No request in IDLE: no array or LRU update.
- pmem_read and pmem_write are never asserted together.
- Reset mid-WRITEBACK or mid-FILL: the transaction is abandoned and strobes drop on the next edge. A late pmem_resp arriving in IDLE is ignored.

Decomposition:
- Package cache_types holds:
  - the state enum (IDLE, WRITEBACK, FILL);
  - localparams S_TAG, S_LINE, and the index and offset widths;
  - the way_t typedef (1 bit).
- One sub-module, cache_array. It is parameterised by width and depth, with combinational read, synchronous write and synchronous reset-to-zero (used for valid, dirty and lru).
  - The data instance carries a 32-bit-granular write mask.
  - Instantiated per way for tag, data, valid and dirty; once for lru.

Test Plan:
- Cold read miss, clean:
  - After reset, read 0x0000_1064 → pmem_read with pmem_address = 0x0000_1060.
  - Return pmem_rdata word1 = 0xDEADBEEF → next cycle mem_resp = 1, mem_rdata = 0xDEADBEEF.
  - No pmem_write at any point.
- Read hit: repeat the read of 0x0000_1064 → mem_resp in the same cycle, no pmem activity, lru[3] points to way1.
- Byte-enable write hit:
  - Write 0x0000_1064 with mem_wdata = 0x11223344 and mem_byte_enable = 4'b0101 → mem_resp same cycle.
  - Read back → 0xDE22BE44.
- LRU and dirty eviction:
  - Read 0x0000_2064 (fills way1).
  - Read 0x0000_3064 → victim is way0 (dirty tag 0x10): pmem_write at 0x0000_1060 with pmem_wdata word1 = 0xDE22BE44, then pmem_read at 0x0000_3060.
  - Only after both complete: mem_resp.
- Clean eviction: read 0x0000_4064 → victim way1 (tag 0x20, clean) → only pmem_read at 0x0000_4060.
- Reset mid-FILL:
  - Assert rst during pmem_read for 0x0000_5064 → pmem_read = 0 next cycle.
  - A stray pmem_resp is ignored.
  - A subsequent read of 0x0000_4064 misses because all valid bits are cleared.
